if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, IF/ID register; 1 instr/cycle at zero-wait memory.
// Backpressure: cStall holds IF/ID and PC, a word arriving under stall is parked in a skid register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cPCSrc,
  input  logic        cPCMux,
  input  logic [31:0] PCSumImm,
  input  logic [31:0] ReadReg1IF,
  input  logic        cStall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] oInstruction,
  output logic [31:0] oPCPlus4,
  output logic [31:0] oPC,
  output logic        oValid
);

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] op4_q, op4_d;
  logic        valid_q, valid_d;

  logic        ack;
  logic [31:0] pc_plus4;
  logic [31:0] tgt_raw;
  logic [31:0] tgt;

  // Ack only counts against a request actually on the bus.
  assign ack      = IMemAck & req_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign tgt_raw  = cPCMux ? ReadReg1IF : PCSumImm;
  assign tgt      = tgt_raw & ~32'h3;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    skid_d  = skid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    op4_d   = op4_q;
    valid_d = valid_q;

    if (cPCSrc) begin
      pc_d    = tgt;
      instr_d = '0;
      valid_d = 1'b0;
      // An unanswered request must still complete before the target is fetched.
      state_d = (req_q && !ack) ? ST_DISCARD : ST_REQ;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (ack) begin
            if (cStall) begin
              skid_d  = IMemData;
              state_d = ST_HOLD;
            end else begin
              instr_d = IMemData;
              opc_d   = pc_q;
              op4_d   = pc_plus4;
              valid_d = 1'b1;
              pc_d    = pc_plus4;
            end
          end else if (!cStall) begin
            valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!cStall) begin
            instr_d = skid_q;
            opc_d   = pc_q;
            op4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            state_d = ST_REQ;
          end
        end
        ST_DISCARD: begin
          valid_d = 1'b0;
          if (ack) begin
            state_d = ST_REQ;
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end

    // Bus outputs are registered; DISCARD keeps the abandoned address stable until its ack.
    req_d  = (state_d != ST_HOLD);
    addr_d = (state_d == ST_DISCARD) ? addr_q : pc_d;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      req_q   <= 1'b0;
      skid_q  <= '0;
      instr_q <= '0;
      opc_q   <= '0;
      op4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      skid_q  <= skid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      op4_q   <= op4_d;
      valid_q <= valid_d;
    end
  end

  assign IMemReq      = req_q;
  assign IMemAddr     = addr_q;
  assign oInstruction = instr_q;
  assign oPCPlus4     = op4_q;
  assign oPC          = opc_q;
  assign oValid       = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed scenarios then randomized traffic, checked against a transaction-level fetch model.
module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'hFFFFFFFC;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        cPCSrc = 1'b0;
  logic        cPCMux = 1'b0;
  logic [31:0] PCSumImm = '0;
  logic [31:0] ReadReg1IF = '0;
  logic        cStall = 1'b0;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemData = '0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] oInstruction;
  logic [31:0] oPCPlus4;
  logic [31:0] oPC;
  logic        oValid;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: program counter, the bus request in flight, whether its
  // data is to be thrown away, a word parked under stall, and the IF/ID view.
  logic [31:0] m_pc, m_addr, m_pw, m_oi, m_opc, m_op4;
  logic        m_req, m_drop, m_park, m_ov;

  if_fetch_unit #(.RESET_PC(RPC)) dut (
    .Clk(Clk), .Reset(Reset), .cPCSrc(cPCSrc), .cPCMux(cPCMux),
    .PCSumImm(PCSumImm), .ReadReg1IF(ReadReg1IF), .cStall(cStall),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
    .oInstruction(oInstruction), .oPCPlus4(oPCPlus4), .oPC(oPC), .oValid(oValid)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req"},   32'(IMemReq), 32'(m_req));
    chk({tag, ".addr"},  IMemAddr, m_addr);
    chk({tag, ".instr"}, oInstruction, m_oi);
    chk({tag, ".pc"},    oPC, m_opc);
    chk({tag, ".pc4"},   oPCPlus4, m_op4);
    chk({tag, ".valid"}, 32'(oValid), 32'(m_ov));
  endtask

  task automatic model_reset();
    m_pc = RPC; m_addr = '0; m_pw = '0; m_oi = '0; m_opc = '0; m_op4 = '0;
    m_req = 1'b0; m_drop = 1'b0; m_park = 1'b0; m_ov = 1'b0;
  endtask

  task automatic model_edge();
    logic        ack;
    logic [31:0] tgt;
    ack = IMemAck && m_req;
    if (cPCSrc) begin
      tgt = cPCMux ? ReadReg1IF : PCSumImm;
      tgt[1:0] = 2'b00;
      m_oi = '0; m_ov = 1'b0; m_park = 1'b0;
      m_drop = m_req && !ack;
      m_pc = tgt;
    end else if (m_drop) begin
      m_ov = 1'b0;
      if (ack) m_drop = 1'b0;
    end else if (m_park) begin
      if (!cStall) begin
        m_oi = m_pw; m_opc = m_pc; m_op4 = m_pc + 32'd4; m_ov = 1'b1;
        m_pc = m_pc + 32'd4; m_park = 1'b0;
      end
    end else if (ack) begin
      if (cStall) begin
        m_pw = IMemData; m_park = 1'b1;
      end else begin
        m_oi = IMemData; m_opc = m_pc; m_op4 = m_pc + 32'd4; m_ov = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else if (!cStall) begin
      m_ov = 1'b0;
    end
    m_req = !m_park;
    if (!m_drop) m_addr = m_pc;
  endtask

  task automatic step(input string tag);
    @(posedge Clk);
    if (Reset) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic cyc(input logic src, input logic stall, input logic ack, input string tag);
    cPCSrc = src; cStall = stall; IMemAck = ack;
    IMemData = word_of(m_addr);
    step(tag);
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    model_reset();
    pulse_reset();
    chk("rst_req", 32'(IMemReq), 32'h0);
    chk("rst_addr", IMemAddr, 32'h0);

    cyc(1'b0, 1'b0, 1'b0, "start");
    chk("start_req", 32'(IMemReq), 32'h1);
    chk("start_addr", IMemAddr, 32'hFFFFFFFC);

    // Zero-wait fetch across the 2^32 wrap
    cyc(1'b0, 1'b0, 1'b1, "zw0");
    chk("zw0_pc", oPC, 32'hFFFFFFFC);
    chk("zw0_pc4", oPCPlus4, 32'h0);
    chk("zw0_addr", IMemAddr, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, "zw1");
    chk("zw1_pc", oPC, 32'h0);
    chk("zw1_addr", IMemAddr, 32'h4);
    cyc(1'b0, 1'b0, 1'b1, "zw2");
    chk("zw2_pc", oPC, 32'h4);
    chk("zw2_pc4", oPCPlus4, 32'h8);
    cyc(1'b0, 1'b0, 1'b1, "zw3");
    chk("zw3_pc4", oPCPlus4, 32'hC);
    chk("zw3_valid", 32'(oValid), 32'h1);

    // Late ack at 0x10
    PCSumImm = 32'h10; cPCMux = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, "redir10");
    chk("redir10_addr", IMemAddr, 32'h10);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, "late");
      chk("late_valid", 32'(oValid), 32'h0);
      chk("late_addr", IMemAddr, 32'h10);
    end
    cyc(1'b0, 1'b0, 1'b1, "late_ack");
    chk("late_instr", oInstruction, word_of(32'h10));
    chk("late_pc", oPC, 32'h10);

    // Ack under stall at 0x20
    PCSumImm = 32'h20;
    cyc(1'b1, 1'b0, 1'b1, "redir20");
    cyc(1'b0, 1'b1, 1'b1, "hold_in");
    chk("hold_in_req", 32'(IMemReq), 32'h0);
    chk("hold_in_pc", oPC, 32'h10);
    cyc(1'b0, 1'b1, 1'b1, "hold");
    chk("hold_req", 32'(IMemReq), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, "hold_out");
    chk("hold_out_instr", oInstruction, word_of(32'h20));
    chk("hold_out_addr", IMemAddr, 32'h24);

    // Redirect while ack pending at 0x40
    PCSumImm = 32'h40;
    cyc(1'b1, 1'b0, 1'b1, "redir40");
    PCSumImm = 32'h100;
    cyc(1'b1, 1'b0, 1'b0, "disc");
    chk("disc_addr", IMemAddr, 32'h40);
    cyc(1'b0, 1'b0, 1'b0, "disc_wait");
    chk("disc_wait_addr", IMemAddr, 32'h40);
    cyc(1'b0, 1'b0, 1'b1, "disc_ack");
    chk("disc_ack_addr", IMemAddr, 32'h100);
    chk("disc_ack_valid", 32'(oValid), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, "f100");
    chk("f100_pc", oPC, 32'h100);

    // Register jump with misaligned target under stall
    cPCMux = 1'b1; ReadReg1IF = 32'h203;
    cyc(1'b1, 1'b1, 1'b1, "jr");
    chk("jr_valid", 32'(oValid), 32'h0);
    chk("jr_addr", IMemAddr, 32'h200);
    cPCMux = 1'b0;

    // Reset in the middle of an outstanding request
    cyc(1'b0, 1'b0, 1'b0, "pre_rst");
    pulse_reset();
    chk("mid_rst_pc", oPC, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, "restart");
    chk("restart_addr", IMemAddr, RPC);

    for (int i = 0; i < 3000; i++) begin
      cPCSrc     = ($urandom_range(0, 7) == 0);
      cPCMux     = 1'($urandom_range(0, 1));
      PCSumImm   = $urandom;
      ReadReg1IF = $urandom;
      cStall     = ($urandom_range(0, 3) == 0);
      IMemAck    = ($urandom_range(0, 2) != 0);
      IMemData   = $urandom;
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
